// File: rtl/conv_stream_feeder_if.sv
// Stream and source-memory bundle for conv_stream_feeder.
// Master is the feeder; slave is the memory/accelerator side.
interface conv_stream_feeder_if #(
  parameter int IO_DATA_WIDTH = 16,
  parameter int ADDR_WIDTH    = 16
);
  logic [ADDR_WIDTH-1:0]    src_mem_read_addr;
  logic                     src_mem_read_en;
  logic [IO_DATA_WIDTH-1:0] src_mem_qout;
  logic [IO_DATA_WIDTH-1:0] a_input;
  logic                     a_valid;
  logic                     a_ready;
  logic [IO_DATA_WIDTH-1:0] b_input;
  logic                     b_valid;
  logic                     b_ready;

  modport master (
    output src_mem_read_addr,
    output src_mem_read_en,
    input  src_mem_qout,
    output a_input,
    output a_valid,
    input  a_ready,
    output b_input,
    output b_valid,
    input  b_ready
  );

  modport slave (
    input  src_mem_read_addr,
    input  src_mem_read_en,
    output src_mem_qout,
    input  a_input,
    input  a_valid,
    output a_ready,
    input  b_input,
    input  b_valid,
    output b_ready
  );
endinterface

// File: rtl/conv_stream_feeder.sv
// Feeds a/b element streams from one single-port memory through a
// round-robin read arbiter and 2-entry per-stream output buffers.
module conv_stream_feeder #(
  parameter int IO_DATA_WIDTH  = 16,
  parameter int SRC_MEM_HEIGHT = 1 << 16,
  parameter int ADDR_WIDTH     = $clog2(SRC_MEM_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  srst_in,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] a_base,
  input  logic [ADDR_WIDTH-1:0] a_count,
  input  logic [ADDR_WIDTH-1:0] b_base,
  input  logic [ADDR_WIDTH-1:0] b_count,
  output logic                  running,
  output logic                  done,
  conv_stream_feeder_if.master  bus
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE = 1;

  state_t state;
  state_t state_nx;

  logic [ADDR_WIDTH-1:0]    base_q [2];
  logic [ADDR_WIDTH-1:0]    cnt_q  [2];
  logic [ADDR_WIDTH-1:0]    iss    [2];
  logic [1:0]               occ    [2];
  logic [IO_DATA_WIDTH-1:0] fifo   [2][2];
  logic                     rp     [2];
  logic                     wp     [2];

  // pend/tag: one read outstanding at most, tag names its stream
  logic pend;
  logic tag;
  logic prio;

  logic [1:0] pop;
  logic [1:0] push;
  logic [1:0] elig;
  logic [1:0] gnt;
  logic [2:0] lvl_a;
  logic [2:0] lvl_b;
  logic       fin;

  assign pop[0]  = (occ[0] != 2'd0) & bus.a_ready;
  assign pop[1]  = (occ[1] != 2'd0) & bus.b_ready;
  assign push[0] = pend & ~tag;
  assign push[1] = pend & tag;

  assign lvl_a = {1'b0, occ[0]} + {2'b0, push[0]};
  assign lvl_b = {1'b0, occ[1]} + {2'b0, push[1]};

  assign elig[0] = (state == RUN) && (iss[0] < cnt_q[0])
                && (lvl_a < 3'd2 + {2'b0, pop[0]});
  assign elig[1] = (state == RUN) && (iss[1] < cnt_q[1])
                && (lvl_b < 3'd2 + {2'b0, pop[1]});

  // prio=1 favours b when both streams contend
  assign gnt[1] = elig[1] & (~elig[0] | prio);
  assign gnt[0] = elig[0] & (~elig[1] | ~prio);

  assign fin = (state == RUN)
            && (iss[0] == cnt_q[0]) && (iss[1] == cnt_q[1])
            && !pend
            && (occ[0] == {1'b0, pop[0]})
            && (occ[1] == {1'b0, pop[1]});

  assign running     = (state == RUN);
  assign bus.a_valid = (occ[0] != 2'd0);
  assign bus.b_valid = (occ[1] != 2'd0);
  assign bus.a_input = fifo[0][rp[0]];
  assign bus.b_input = fifo[1][rp[1]];

  always_comb begin
    state_nx              = state;
    done                  = 1'b0;
    bus.src_mem_read_en   = 1'b0;
    bus.src_mem_read_addr = '0;
    if (gnt[1]) begin
      bus.src_mem_read_en   = 1'b1;
      bus.src_mem_read_addr = base_q[1] + iss[1];
    end else if (gnt[0]) begin
      bus.src_mem_read_en   = 1'b1;
      bus.src_mem_read_addr = base_q[0] + iss[0];
    end
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        if (fin) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst_in) begin
      state <= IDLE;
      pend  <= 1'b0;
      tag   <= 1'b0;
      prio  <= 1'b0;
      for (int s = 0; s < 2; s++) begin
        base_q[s]  <= '0;
        cnt_q[s]   <= '0;
        iss[s]     <= '0;
        occ[s]     <= '0;
        rp[s]      <= 1'b0;
        wp[s]      <= 1'b0;
        fifo[s][0] <= '0;
        fifo[s][1] <= '0;
      end
    end else begin
      state <= state_nx;
      pend  <= |gnt;
      tag   <= gnt[1];
      if (|gnt) prio <= gnt[0];
      if (state == IDLE && start) begin
        base_q[0] <= a_base;
        cnt_q[0]  <= a_count;
        base_q[1] <= b_base;
        cnt_q[1]  <= b_count;
        iss[0]    <= '0;
        iss[1]    <= '0;
        prio      <= 1'b0;
      end
      for (int s = 0; s < 2; s++) begin
        if (gnt[s]) iss[s] <= iss[s] + ONE;
        if (push[s]) begin
          fifo[s][wp[s]] <= bus.src_mem_qout;
          wp[s]          <= ~wp[s];
        end
        if (pop[s]) rp[s] <= ~rp[s];
        unique case ({push[s], pop[s]})
          2'b10:   occ[s] <= occ[s] + 2'd1;
          2'b01:   occ[s] <= occ[s] - 2'd1;
          default: occ[s] <= occ[s];
        endcase
      end
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (srst_in)
    !(push[0] && occ[0] == 2'd2));
  b_no_overflow: assert property (
    @(posedge clk) disable iff (srst_in)
    !(push[1] && occ[1] == 2'd2));

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Directed bench for conv_stream_feeder: memory model, read log,
// and per-stream expected-data queues checked on each handshake.
module tb_conv_stream_feeder;

  logic        clk = 1'b0;
  logic        srst_in;
  logic        start;
  logic [15:0] a_base;
  logic [15:0] a_count;
  logic [15:0] b_base;
  logic [15:0] b_count;
  logic        running;
  logic        done;

  conv_stream_feeder_if #(.IO_DATA_WIDTH(16), .ADDR_WIDTH(16)) bus ();

  conv_stream_feeder #(
    .IO_DATA_WIDTH(16),
    .SRC_MEM_HEIGHT(1 << 16),
    .ADDR_WIDTH(16)
  ) dut (
    .clk(clk),
    .srst_in(srst_in),
    .start(start),
    .a_base(a_base),
    .a_count(a_count),
    .b_base(b_base),
    .b_count(b_count),
    .running(running),
    .done(done),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];
  always @(posedge clk)
    if (bus.src_mem_read_en) bus.src_mem_qout <= mem[bus.src_mem_read_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails = 0;
  int t0 = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int a_first = -1;
  bit any_valid = 0;
  logic [15:0] sb_a [$];
  logic [15:0] sb_b [$];
  logic [15:0] rd_addr_q [$];
  int rd_cyc_q [$];
  bit a_stall = 0;
  bit b_stall = 0;
  logic [15:0] a_hold;
  logic [15:0] b_hold;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (srst_in) begin
      a_stall = 0;
      b_stall = 0;
    end else begin
      if (bus.src_mem_read_en) begin
        rd_addr_q.push_back(bus.src_mem_read_addr);
        rd_cyc_q.push_back(cyc - t0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc - t0;
      end
      if (bus.a_valid || bus.b_valid) any_valid = 1;
      if (bus.a_valid && a_first < 0) a_first = cyc - t0;
      if (a_stall) begin
        chk("a_hold_valid", bus.a_valid, 1);
        chk("a_hold_data", bus.a_input, a_hold);
      end
      if (b_stall) begin
        chk("b_hold_valid", bus.b_valid, 1);
        chk("b_hold_data", bus.b_input, b_hold);
      end
      if (bus.a_valid && bus.a_ready) begin
        if (sb_a.size() == 0) chk("a_unexpected", 1, 0);
        else chk("a_data", bus.a_input, sb_a.pop_front());
      end
      if (bus.b_valid && bus.b_ready) begin
        if (sb_b.size() == 0) chk("b_unexpected", 1, 0);
        else chk("b_data", bus.b_input, sb_b.pop_front());
      end
      a_stall = bus.a_valid && !bus.a_ready;
      b_stall = bus.b_valid && !bus.b_ready;
      a_hold  = bus.a_input;
      b_hold  = bus.b_input;
    end
  end

  task automatic run_job(input logic [15:0] ab, input logic [15:0] ac,
                         input logic [15:0] bb, input logic [15:0] bc);
    logic [15:0] ad;
    for (int i = 0; i < int'(ac); i++) begin
      ad = ab + 16'(i);
      sb_a.push_back(mem[ad]);
    end
    for (int i = 0; i < int'(bc); i++) begin
      ad = bb + 16'(i);
      sb_b.push_back(mem[ad]);
    end
    rd_addr_q.delete();
    rd_cyc_q.delete();
    done_cnt  = 0;
    done_cyc  = -1;
    a_first   = -1;
    any_valid = 0;
    @(posedge clk); #1;
    a_base  = ab;
    a_count = ac;
    b_base  = bb;
    b_count = bc;
    start   = 1;
    t0      = cyc;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", done_cnt != 0, 1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_running"}, running, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, bus.src_mem_read_en, 0);
    chk({tag, "_rd_addr"}, bus.src_mem_read_addr, 0);
    chk({tag, "_a_valid"}, bus.a_valid, 0);
    chk({tag, "_b_valid"}, bus.b_valid, 0);
    chk({tag, "_a_input"}, bus.a_input, 0);
    chk({tag, "_b_input"}, bus.b_input, 0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i);
    srst_in = 1;
    start = 0;
    a_base = 0;
    a_count = 0;
    b_base = 0;
    b_count = 0;
    bus.a_ready = 0;
    bus.b_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    srst_in = 0;

    // single a stream at full rate
    bus.a_ready = 1;
    bus.b_ready = 1;
    run_job(16'h10, 16'd4, 16'h0, 16'd0);
    wait_done(30);
    chk("t1_running_low", running, 0);
    chk("t1_done_cyc", done_cyc, 6);
    chk("t1_a_first", a_first, 3);
    chk("t1_nreads", rd_addr_q.size(), 4);
    for (int i = 0; i < 4 && i < rd_addr_q.size(); i++) begin
      chk("t1_rd_addr", rd_addr_q[i], 32'h10 + i);
      chk("t1_rd_cyc", rd_cyc_q[i], i + 1);
    end
    chk("t1_sb_a_empty", sb_a.size(), 0);

    // both streams stalled: arbitration order and held heads
    bus.a_ready = 0;
    bus.b_ready = 0;
    run_job(16'h0, 16'd2, 16'h100, 16'd2);
    repeat (10) @(posedge clk);
    #1;
    chk("t2_nreads", rd_addr_q.size(), 4);
    if (rd_addr_q.size() == 4) begin
      chk("t2_rd0", rd_addr_q[0], 32'h000);
      chk("t2_rd1", rd_addr_q[1], 32'h100);
      chk("t2_rd2", rd_addr_q[2], 32'h001);
      chk("t2_rd3", rd_addr_q[3], 32'h101);
    end
    chk("t2_a_input", bus.a_input, 32'h0000);
    chk("t2_b_input", bus.b_input, 32'h0100);
    chk("t2_a_valid", bus.a_valid, 1);
    chk("t2_b_valid", bus.b_valid, 1);
    chk("t2_running", running, 1);

    // release a only
    bus.a_ready = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("t3_sb_a_empty", sb_a.size(), 0);
    chk("t3_a_valid", bus.a_valid, 0);
    chk("t3_b_valid", bus.b_valid, 1);
    chk("t3_b_input", bus.b_input, 32'h0100);
    chk("t3_no_done", done_cnt, 0);
    chk("t3_running", running, 1);
    bus.b_ready = 1;
    wait_done(30);
    chk("t3_sb_b_empty", sb_b.size(), 0);

    // address wrap
    run_job(16'hFFFE, 16'd4, 16'h0, 16'd0);
    wait_done(30);
    chk("t4_nreads", rd_addr_q.size(), 4);
    if (rd_addr_q.size() == 4) begin
      chk("t4_rd0", rd_addr_q[0], 32'hFFFE);
      chk("t4_rd1", rd_addr_q[1], 32'hFFFF);
      chk("t4_rd2", rd_addr_q[2], 32'h0000);
      chk("t4_rd3", rd_addr_q[3], 32'h0001);
    end
    chk("t4_sb_a_empty", sb_a.size(), 0);

    // empty job
    run_job(16'h40, 16'd0, 16'h80, 16'd0);
    wait_done(10);
    chk("t5_done_cyc", done_cyc, 1);
    chk("t5_nreads", rd_addr_q.size(), 0);
    chk("t5_no_valid", any_valid, 0);

    // reset mid-job with a read in flight
    run_job(16'h20, 16'd8, 16'h0, 16'd0);
    @(posedge clk); #1;
    srst_in = 1;
    sb_a.delete();
    @(posedge clk); #1;
    srst_in = 0;
    chk_idle_outputs("t6_after_rst");
    repeat (4) @(posedge clk);
    #1;
    chk("t6_a_valid", bus.a_valid, 0);
    chk("t6_no_done", done_cnt, 0);
    chk("t6_running", running, 0);
    run_job(16'h20, 16'd8, 16'h0, 16'd0);
    wait_done(40);
    chk("t6_nreads", rd_addr_q.size(), 8);
    if (rd_addr_q.size() > 0) chk("t6_first_addr", rd_addr_q[0], 32'h20);
    chk("t6_sb_a_empty", sb_a.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/conv_stream_feeder.md
Name: conv_stream_feeder

Overview:
Transmit-side counterpart of the accelerator's a/b streaming inputs. Reads activation (a) and weight (b) elements from a shared single-port source memory and drives them to the accelerator over two independent valid/ready streams. The two streams share the memory read port through a round-robin arbiter. Each stream has a 2-entry output buffer to hide the 1-cycle memory read latency and absorb backpressure.

Parameters:
IO_DATA_WIDTH, 16, element width on a/b streams and memory word width
SRC_MEM_HEIGHT, 1<<16, source memory depth in words
ADDR_WIDTH, $clog2(SRC_MEM_HEIGHT), address and count width

Ports:
clk  input  1  clock
srst_in  input  1  synchronous reset, active-high
start  input  1  start pulse; sampled only when idle
a_base  input  ADDR_WIDTH  first word address of a stream; sampled with start
a_count  input  ADDR_WIDTH  number of a elements; sampled with start
b_base  input  ADDR_WIDTH  first word address of b stream; sampled with start
b_count  input  ADDR_WIDTH  number of b elements; sampled with start
running  output  1  high from the start edge until the job completes
done  output  1  1-cycle pulse on completion
src_mem_read_addr  output  ADDR_WIDTH  memory read address
src_mem_read_en  output  1  memory read strobe
src_mem_qout  input  IO_DATA_WIDTH  read data, valid the cycle after read_en
a_input  output  IO_DATA_WIDTH  a stream data
a_valid  output  1  a stream valid
a_ready  input  1  a stream ready
b_input  output  IO_DATA_WIDTH  b stream data
b_valid  output  1  b stream valid
b_ready  input  1  b stream ready

Behaviour:
- One clock. Reset is synchronous and active-high. The clock port is clk and the reset port is srst_in.
- Reset: running=0, done=0, src_mem_read_en=0, src_mem_read_addr=0, a_valid=b_valid=0, a_input=b_input=0. Buffers are emptied, counters cleared, and any in-flight read tag is dropped.
- Reset asserted mid-job: the job is aborted, no done pulse is generated, and the response returning next cycle is discarded.
- States: IDLE and RUN.
  - IDLE→RUN on start: latch bases and counts; running=1 from the next cycle.
  - RUN→IDLE when both streams have issued all reads, both buffers are empty and no read is in flight. done=1 for exactly that cycle; running=0 the following cycle.
  - start asserted while in RUN is ignored.
- Per-stream state: issue counter (0..count), buffer occupancy (0..2), in-flight flag.
  - Stream X is eligible when issued<count AND occupancy + inflight − pop_this_cycle < 2.
  - pop_this_cycle = X_valid && X_ready.
- Arbiter: at most one read per cycle.
  - If only one stream is eligible, it is granted.
  - If both are eligible, the priority stream is granted. Priority toggles to the other stream after each grant; priority is a after start.
- Read issue: src_mem_read_en=1 and src_mem_read_addr=(base+issued) mod 2^ADDR_WIDTH are driven combinationally from registered state in the grant cycle. A 1-bit tag register records the granted stream.
- Response: src_mem_qout is written into the tagged stream's buffer at the end of the cycle after the grant.
- Stream outputs: X_valid = (occupancy>0), registered. X_input = buffer head. The buffer is FIFO-ordered.
- X_valid never deasserts without a handshake. X_input is stable while X_valid && !X_ready.
- Simultaneous push and pop on the same buffer: occupancy is unchanged. A push into a full buffer is impossible by construction; assert this in simulation.
- Latency: start in cycle 0 → first read_en in cycle 1 → data enters buffer end of cycle 2 → a_valid in cycle 3.
- Throughput: a single active stream with ready held high sustains 1 element/cycle.
- count=0: that stream issues nothing. If both counts are 0, done pulses in cycle 1.
- Counts are unsigned. Address arithmetic wraps modulo 2^ADDR_WIDTH.

Test Plan:
- a_base=0x10, a_count=4, b_count=0, a_ready=1, mem[i]=i → read_en cycles 1–4, addrs 0x10..0x13; a_valid cycles 3–6 with data 0x10..0x13; done in cycle 6; running low in cycle 7.
- a_count=2 (base 0), b_count=2 (base 0x100), both ready=0 → read addrs in order 0x000, 0x100, 0x001, 0x101; then no reads; a_input=0x0000 and b_input=0x0100 held stable.
- Same as above, then release a_ready only → a delivers 0,1; b stays valid on 0x100 with no b handshake; done is not asserted.
- a_base=0xFFFE (ADDR_WIDTH=16), a_count=4 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001; four elements delivered in order.
- a_count=b_count=0 with start → done=1 in cycle 1; no read_en; a_valid and b_valid never assert.
- srst_in pulsed while a_count=8 is mid-job with a read in flight → all outputs 0 next cycle, returning data discarded, no done pulse; a new start runs cleanly from base.
